// File: rtl/param_stream_pkg.sv
// Shared types and sizing helpers for the parameter ROM streamer.
// The FIFO depth helper keeps the top and the buffer agreeing on default sizes.
package param_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_ROM_LATENCY = 2;

  // Two entries beyond the ROM pipeline let reads keep flowing at one beat per cycle.
  function automatic int fifo_depth_for(input int rom_latency);
    return rom_latency + 2;
  endfunction

  localparam int DEFAULT_FIFO_DEPTH = fifo_depth_for(DEFAULT_ROM_LATENCY);

endpackage

// File: rtl/param_stream_fifo.sv
// First-word fall-through FIFO with async reset carrying {last, data} beats.
// A push is accepted while full when the head is popped in the same cycle.
module param_stream_fifo
  import param_stream_pkg::*;
#(
  parameter int WIDTH = 513,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return PW'(0);
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Qualify push/pop against occupancy.
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    do_pop_s  = pop && (count_r != CW'(0));
    do_push_s = push && (!full_s || do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign empty = (count_r == CW'(0));
  assign count = count_r;

endmodule

// File: rtl/param_rom_stream_ctrl.sv
// Sequences reads from a fixed-latency parameter ROM into a valid/ready stream,
// replaying the whole tensor num_passes times per start command.
module param_rom_stream_ctrl
  import param_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int OUT_DEPTH   = 32,
  parameter int ROM_LATENCY = DEFAULT_ROM_LATENCY,
  parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1,
  parameter int PASS_WIDTH  = 16,
  parameter int FIFO_DEPTH  = fifo_depth_for(ROM_LATENCY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(ROM_LATENCY + FIFO_DEPTH + 1);

  state_t                  state_r;
  state_t                  state_next_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [ADDR_WIDTH-1:0]   rom_addr_r;
  logic [PASS_WIDTH-1:0]   pass_cnt_r;
  logic [PASS_WIDTH-1:0]   passes_r;
  logic [ROM_LATENCY-1:0]  tag_r;
  logic [ROM_LATENCY-1:0]  last_tag_r;
  logic                    busy_r;
  logic                    done_r;
  logic [CW-1:0]           fifo_count_s;
  logic                    fifo_empty_s;
  logic [DATA_WIDTH:0]     fifo_head_s;
  logic [SW-1:0]           inflight_s;
  logic [SW-1:0]           occupancy_s;
  logic                    issue_s;
  logic                    addr_end_s;
  logic                    final_issue_s;
  logic                    accept_s;
  logic                    push_s;

  // Reads are issued only while every outstanding word is guaranteed a FIFO slot.
  always_comb begin
    inflight_s = SW'(0);
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight_s = inflight_s + SW'(tag_r[i]);
    end
    occupancy_s   = inflight_s + SW'(fifo_count_s);
    addr_end_s    = (addr_r == ADDR_WIDTH'(OUT_DEPTH - 1));
    issue_s       = (state_r == S_RUN) && (occupancy_s < SW'(FIFO_DEPTH));
    final_issue_s = issue_s && addr_end_s && (pass_cnt_r == passes_r - PASS_WIDTH'(1));
    accept_s      = (state_r == S_IDLE) && start && (num_passes != PASS_WIDTH'(0));
    push_s        = tag_r[ROM_LATENCY-1];
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_next_s = (num_passes != PASS_WIDTH'(0)) ? S_RUN : S_DONE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (final_issue_s) begin
          state_next_s = S_DRAIN;
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if ((inflight_s == SW'(0)) && fifo_empty_s && !push_s) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_DRAIN;
        end
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == S_RUN) || (state_next_s == S_DRAIN);
      done_r  <= (state_next_s == S_DONE);
    end
  end

  // rom_addr is the first ROM pipeline stage, so ROM_LATENCY counts from the issue cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r     <= ADDR_WIDTH'(0);
      rom_addr_r <= ADDR_WIDTH'(0);
      pass_cnt_r <= PASS_WIDTH'(0);
      passes_r   <= PASS_WIDTH'(0);
      tag_r      <= ROM_LATENCY'(0);
      last_tag_r <= ROM_LATENCY'(0);
    end else begin
      if (accept_s) begin
        passes_r   <= num_passes;
        addr_r     <= ADDR_WIDTH'(0);
        pass_cnt_r <= PASS_WIDTH'(0);
      end else if (issue_s) begin
        rom_addr_r <= addr_r;
        if (addr_end_s) begin
          addr_r     <= ADDR_WIDTH'(0);
          pass_cnt_r <= pass_cnt_r + PASS_WIDTH'(1);
        end else begin
          addr_r <= addr_r + ADDR_WIDTH'(1);
        end
      end
      tag_r[0]      <= issue_s;
      last_tag_r[0] <= issue_s && addr_end_s;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_r[i]      <= tag_r[i-1];
        last_tag_r[i] <= last_tag_r[i-1];
      end
    end
  end

  param_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data ({last_tag_r[ROM_LATENCY-1], rom_q}),
    .pop       (data_out_ready),
    .head      (fifo_head_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign busy           = busy_r;
  assign done           = done_r;
  assign rom_addr       = rom_addr_r;
  assign rom_ce         = ~rst;
  assign data_out       = fifo_head_s[DATA_WIDTH-1:0];
  assign data_out_valid = ~fifo_empty_s;
  assign data_out_last  = fifo_head_s[DATA_WIDTH] & ~fifo_empty_s;

endmodule
